// File: rtl/ddr_cmd_sched.sv
// ---------------------------------------------------------------------------
// ddr_cmd_sched
// DDR command scheduler and strobe sequencer (single clock domain).
// Takes packed {ras_n,cas_n,we_n,ba,a} commands from the CBA fifo read side
// over valid/ready and drives each one to the pad registers for one cycle.
// After an accept, further commands are held off for an opcode-specific
// spacing. Read-sample, write-data and DQS enable windows are generated from
// shift registers, and a free-running counter raises auto-refresh requests.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   cmd_valid    command available
//   cmd_data     {ras_n,cas_n,we_n,ba,a}
//   cmd_ready    command accepted when cmd_valid & cmd_ready
//   ddr_ras_n / ddr_cas_n / ddr_we_n / ddr_ba / ddr_a   registered command pins
//   rd_sample    read-data capture enable
//   wr_data_ack  pop one write-data word per cycle
//   dqs_oe       DQS/DQ output enable, includes one preamble cycle
//   dqs_en       DQS toggle enable
//   ref_req      refresh due
//   busy         timer running or any strobe window active
// ---------------------------------------------------------------------------
module ddr_cmd_sched #(
    parameter int A_WIDTH      = 13,
    parameter int BA_WIDTH     = 2,
    parameter int BURST_LEN    = 4,
    parameter int T_MRS        = 2,
    parameter int T_AR         = 14,
    parameter int T_ACT        = 4,
    parameter int T_PRE        = 2,
    parameter int T_RD         = 6,
    parameter int T_WR         = 8,
    parameter int RD_DLY       = 3,
    parameter int REF_INTERVAL = 780
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    input  logic [3+BA_WIDTH+A_WIDTH-1:0] cmd_data,
    output logic                          cmd_ready,
    output logic                          ddr_ras_n,
    output logic                          ddr_cas_n,
    output logic                          ddr_we_n,
    output logic [BA_WIDTH-1:0]           ddr_ba,
    output logic [A_WIDTH-1:0]            ddr_a,
    output logic                          rd_sample,
    output logic                          wr_data_ack,
    output logic                          dqs_oe,
    output logic                          dqs_en,
    output logic                          ref_req,
    output logic                          busy
);

    function automatic int max_of(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    localparam int CMD_W    = 3 + BA_WIDTH + A_WIDTH;
    localparam int BL2      = BURST_LEN / 2;
    localparam int RD_DEPTH = RD_DLY + BL2;
    localparam int WR_DEPTH = BL2 + 1;
    localparam int T_MAX    = max_of(max_of(max_of(T_MRS, T_AR), max_of(T_ACT, T_PRE)),
                                     max_of(T_RD, T_WR));
    localparam int TMR_W    = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);
    localparam int REF_W    = (REF_INTERVAL < 1) ? 1 : $clog2(REF_INTERVAL + 1);

    localparam logic [2:0] OP_MRS   = 3'b000;
    localparam logic [2:0] OP_AR    = 3'b001;
    localparam logic [2:0] OP_PRE   = 3'b010;
    localparam logic [2:0] OP_ACT   = 3'b011;
    localparam logic [2:0] OP_WRITE = 3'b100;
    localparam logic [2:0] OP_READ  = 3'b101;

    localparam logic [CMD_W-1:0] NOP_WORD = {3'b111, {(BA_WIDTH + A_WIDTH){1'b0}}};

    // Parameter sanity: these combinations would let strobe windows overlap.
    if (BURST_LEN != 2 && BURST_LEN != 4 && BURST_LEN != 8) begin : g_bad_bl
        $error("ddr_cmd_sched: BURST_LEN must be 2, 4 or 8");
    end
    if (T_RD < RD_DLY + BL2) begin : g_bad_trd
        $error("ddr_cmd_sched: T_RD must be >= RD_DLY + BURST_LEN/2");
    end
    if (T_WR < BL2 + 1) begin : g_bad_twr
        $error("ddr_cmd_sched: T_WR must be >= BURST_LEN/2 + 1");
    end

    logic [TMR_W-1:0]    tmr_q,     tmr_d;
    logic [CMD_W-1:0]    pad_q,     pad_d;
    logic [RD_DEPTH-1:0] rd_sr_q,   rd_sr_d;
    logic [WR_DEPTH-1:0] wr_sr_q,   wr_sr_d;
    logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;

    logic       accept_s;
    logic [2:0] op_s;

    assign op_s      = cmd_data[CMD_W-1 -: 3];
    assign cmd_ready = (tmr_q == {TMR_W{1'b0}}) & ~reset;
    assign accept_s  = cmd_valid & cmd_ready;

    // Next-state: spacing timer, pad word, strobe shift registers, refresh counter.
    always_comb begin
        tmr_d     = tmr_q;
        pad_d     = NOP_WORD;
        rd_sr_d   = rd_sr_q << 1;
        wr_sr_d   = wr_sr_q << 1;
        ref_cnt_d = ref_cnt_q;

        if (tmr_q != {TMR_W{1'b0}}) begin
            tmr_d = tmr_q - TMR_W'(1);
        end else begin
            tmr_d = {TMR_W{1'b0}};
        end

        if (accept_s) begin
            pad_d = cmd_data;
            case (op_s)
                OP_MRS:   tmr_d = TMR_W'(T_MRS);
                OP_AR:    tmr_d = TMR_W'(T_AR);
                OP_ACT:   tmr_d = TMR_W'(T_ACT);
                OP_PRE:   tmr_d = TMR_W'(T_PRE);
                OP_READ:  tmr_d = TMR_W'(T_RD);
                OP_WRITE: tmr_d = TMR_W'(T_WR);
                default:  tmr_d = {TMR_W{1'b0}};
            endcase
            // Bit 0 marks the cycle the command sits on the pads.
            if (op_s == OP_READ) begin
                rd_sr_d = rd_sr_d | RD_DEPTH'(1);
            end else begin
                rd_sr_d = rd_sr_d;
            end
            if (op_s == OP_WRITE) begin
                wr_sr_d = wr_sr_d | WR_DEPTH'(1);
            end else begin
                wr_sr_d = wr_sr_d;
            end
        end else begin
            pad_d = NOP_WORD;
        end

        // Accepting AR wins over the increment; the count saturates at the interval.
        if (REF_INTERVAL == 0) begin
            ref_cnt_d = {REF_W{1'b0}};
        end else if (accept_s && (op_s == OP_AR)) begin
            ref_cnt_d = {REF_W{1'b0}};
        end else if (ref_cnt_q != REF_W'(REF_INTERVAL)) begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
        end else begin
            ref_cnt_d = ref_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q     <= {TMR_W{1'b0}};
            pad_q     <= NOP_WORD;
            rd_sr_q   <= {RD_DEPTH{1'b0}};
            wr_sr_q   <= {WR_DEPTH{1'b0}};
            ref_cnt_q <= {REF_W{1'b0}};
        end else begin
            tmr_q     <= tmr_d;
            pad_q     <= pad_d;
            rd_sr_q   <= rd_sr_d;
            wr_sr_q   <= wr_sr_d;
            ref_cnt_q <= ref_cnt_d;
        end
    end

    assign ddr_ras_n = pad_q[CMD_W-1];
    assign ddr_cas_n = pad_q[CMD_W-2];
    assign ddr_we_n  = pad_q[CMD_W-3];
    assign ddr_ba    = pad_q[A_WIDTH +: BA_WIDTH];
    assign ddr_a     = pad_q[A_WIDTH-1:0];

    // Read window: shift taps RD_DLY .. RD_DLY+BL2-1 after the READ pad cycle.
    assign rd_sample   = |rd_sr_q[RD_DEPTH-1:RD_DLY];
    // Write: tap 0 is the DQS preamble, taps 1..BL2 carry data.
    assign dqs_oe      = |wr_sr_q;
    assign dqs_en      = |wr_sr_q[WR_DEPTH-1:1];
    assign wr_data_ack = |wr_sr_q[WR_DEPTH-1:1];

    assign ref_req = (REF_INTERVAL != 0) && (ref_cnt_q == REF_W'(REF_INTERVAL));
    assign busy    = (tmr_q != {TMR_W{1'b0}}) | (|rd_sr_q) | (|wr_sr_q);

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_ddr_cmd_sched
// Randomized scoreboard bench. The stimulus process keeps a cycle-level
// reference model made of event times (next ready cycle, READ/WRITE pad
// cycles, last refresh clear) and pushes the expected outputs for every cycle;
// a separate monitor pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_ddr_cmd_sched;

    localparam int A_W    = 13;
    localparam int BA_W   = 2;
    localparam int BL     = 4;
    localparam int BL2    = BL / 2;
    localparam int TMRS   = 2;
    localparam int TAR    = 14;
    localparam int TACT   = 4;
    localparam int TPRE   = 2;
    localparam int TRD    = 6;
    localparam int TWR    = 8;
    localparam int RDDLY  = 3;
    localparam int RI     = 780;
    localparam int CMD_W  = 3 + BA_W + A_W;
    localparam int NCYC   = 3200;

    typedef struct packed {
        logic            rdy;
        logic [2:0]      op;
        logic [BA_W-1:0] ba;
        logic [A_W-1:0]  a;
        logic            rds;
        logic            wack;
        logic            oe;
        logic            en;
        logic            rr;
        logic            busy;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [CMD_W-1:0] cmd_data;
    logic             cmd_ready;
    logic             ddr_ras_n, ddr_cas_n, ddr_we_n;
    logic [BA_W-1:0]  ddr_ba;
    logic [A_W-1:0]   ddr_a;
    logic             rd_sample, wr_data_ack, dqs_oe, dqs_en, ref_req, busy;

    always #5 clk = ~clk;

    ddr_cmd_sched #(
        .A_WIDTH(A_W), .BA_WIDTH(BA_W), .BURST_LEN(BL),
        .T_MRS(TMRS), .T_AR(TAR), .T_ACT(TACT), .T_PRE(TPRE),
        .T_RD(TRD), .T_WR(TWR), .RD_DLY(RDDLY), .REF_INTERVAL(RI)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n),
        .ddr_we_n(ddr_we_n), .ddr_ba(ddr_ba), .ddr_a(ddr_a),
        .rd_sample(rd_sample), .wr_data_ack(wr_data_ack), .dqs_oe(dqs_oe),
        .dqs_en(dqs_en), .ref_req(ref_req), .busy(busy)
    );

    obs_t exp_q[$];
    int   cyc_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic int spacing(input logic [2:0] op);
        case (op)
            3'b000:  return TMRS;
            3'b001:  return TAR;
            3'b011:  return TACT;
            3'b010:  return TPRE;
            3'b101:  return TRD;
            3'b100:  return TWR;
            default: return 0;
        endcase
    endfunction

    // Monitor: compare the DUT against the next expected cycle on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                obs_t e, g;
                int   c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                g.rdy  = cmd_ready;
                g.op   = {ddr_ras_n, ddr_cas_n, ddr_we_n};
                g.ba   = ddr_ba;
                g.a    = ddr_a;
                g.rds  = rd_sample;
                g.wack = wr_data_ack;
                g.oe   = dqs_oe;
                g.en   = dqs_en;
                g.rr   = ref_req;
                g.busy = busy;
                n_checks++;
                if (g === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL cycle_%0d outputs got rdy=%b op=%b ba=%h a=%h rds=%b wack=%b oe=%b en=%b rr=%b busy=%b, exp rdy=%b op=%b ba=%h a=%h rds=%b wack=%b oe=%b en=%b rr=%b busy=%b",
                             c, g.rdy, g.op, g.ba, g.a, g.rds, g.wack, g.oe, g.en, g.rr, g.busy,
                             e.rdy, e.op, e.ba, e.a, e.rds, e.wack, e.oe, e.en, e.rr, e.busy);
                end
            end
        end
    end

    // Stimulus and reference model.
    initial begin
        int               rq[$];
        int               wq[$];
        int               ready_at;
        int               base;
        logic [CMD_W-1:0] pad_cur;
        logic [CMD_W-1:0] nop_w;
        logic [CMD_W-1:0] d;
        logic [2:0]       op;
        logic             v, r, acc;
        bit               did_rst;
        obs_t             e;

        nop_w     = {3'b111, {(BA_W + A_W){1'b0}}};
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        ready_at = 0;
        base     = 0;
        pad_cur  = nop_w;
        did_rst  = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            // ---- choose stimulus for this cycle ----
            v  = 1'b0;
            r  = 1'b0;
            op = 3'b111;
            if (c < 800) begin
                v = 1'b1;
                case (c)
                    10, 15:  op = 3'b011;
                    20:      op = 3'b100;
                    29:      op = 3'b101;
                    40:      op = 3'b010;
                    43:      op = 3'b000;
                    46:      op = 3'b110;
                    47:      op = 3'b111;
                    48:      op = 3'b100;
                    default: v = 1'b0;
                endcase
            end else if (c < 1000 || (c >= 1030 && c < 1900)) begin
                v  = ($urandom_range(0, 1) == 1);
                op = 3'($urandom_range(0, 7));
                if (op == 3'b001) op = 3'b101;
            end else if (c < 1030) begin
                v  = 1'b1;
                op = 3'b001;
            end else if (c < 1950) begin
                v  = 1'b1;
                op = 3'b100;
                if (!did_rst && wq.size() > 0 && wq[wq.size()-1] == c - 1) begin
                    r       = 1'b1;
                    did_rst = 1'b1;
                end
            end else begin
                v  = ($urandom_range(0, 2) != 0);
                op = 3'($urandom_range(0, 7));
                r  = ($urandom_range(0, 63) == 0);
            end
            d = {op, BA_W'($urandom), A_W'($urandom)};

            reset     = r;
            cmd_valid = v;
            cmd_data  = d;

            // ---- expected outputs for this cycle ----
            e.rdy  = !r && (c >= ready_at);
            e.op   = pad_cur[CMD_W-1 -: 3];
            e.ba   = pad_cur[A_W +: BA_W];
            e.a    = pad_cur[A_W-1:0];
            e.rds  = 1'b0;
            e.oe   = 1'b0;
            e.en   = 1'b0;
            e.busy = (c < ready_at);
            foreach (rq[i]) begin
                if (c >= rq[i] + RDDLY && c <= rq[i] + RDDLY + BL2 - 1) e.rds = 1'b1;
                if (c >= rq[i] && c <= rq[i] + RDDLY + BL2 - 1) e.busy = 1'b1;
            end
            foreach (wq[i]) begin
                if (c >= wq[i] && c <= wq[i] + BL2) e.oe = 1'b1;
                if (c >= wq[i] + 1 && c <= wq[i] + BL2) e.en = 1'b1;
            end
            e.wack = e.en;
            e.busy = e.busy | e.oe;
            e.rr   = (RI != 0) && (c - base >= RI);
            exp_q.push_back(e);
            cyc_q.push_back(c);

            // ---- advance the model ----
            acc = v && e.rdy;
            if (r) begin
                rq.delete();
                wq.delete();
                ready_at = c + 1;
                base     = c + 1;
                pad_cur  = nop_w;
            end else if (acc) begin
                pad_cur  = d;
                ready_at = c + 1 + spacing(op);
                if (op == 3'b101) rq.push_back(c + 1);
                if (op == 3'b100) wq.push_back(c + 1);
                if (op == 3'b001) base = c + 1;
            end else begin
                pad_cur = nop_w;
            end
            while (rq.size() > 0 && rq[0] + 40 < c) void'(rq.pop_front());
            while (wq.size() > 0 && wq[0] + 40 < c) void'(wq.pop_front());

            @(posedge clk);
            #1;
        end

        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
